// File: rtl/crc16_checker.sv
// ============================================================================
// crc16_checker
// Receive-side CRC16 (x^16+x^12+x^5+1) residue checker that strips the
// trailing CRC word and reports a per-frame verdict with saturating counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module crc16_checker #(
    parameter logic [15:0] INIT  = 16'hFFFF,
    parameter int          CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_din_valid,
    input  logic             i_din_sop,
    input  logic             i_din_eop,
    input  logic [15:0]      i_din,
    output logic             o_dout_valid,
    output logic             o_dout_sop,
    output logic             o_dout_eop,
    output logic [15:0]      o_dout,
    output logic             o_chk_valid,
    output logic             o_chk_ok,
    output logic             o_chk_err_crc,
    output logic             o_chk_err_frame,
    output logic [CNT_W-1:0] o_good_cnt,
    output logic [CNT_W-1:0] o_bad_cnt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } state_t;

    localparam logic [15:0] c_POLY = 16'h1021;

    // Sixteen unrolled shift/XOR steps; collapses to a pure XOR matrix.
    function automatic logic [15:0] crc_g(input logic [15:0] v_in);
        logic [15:0] v;
        v = v_in;
        for (int i = 0; i < 16; i++) begin
            v = {v[14:0], 1'b0} ^ (v[15] ? c_POLY : 16'h0000);
        end
        return v;
    endfunction

    state_t             r_state, w_state_nxt;
    logic [15:0]        r_crc, w_crc_nxt;
    logic [15:0]        r_hold, w_hold_nxt;
    logic               r_hold_sop, w_hold_sop_nxt;
    logic [CNT_W-1:0]   r_good_cnt, w_good_cnt_nxt;
    logic [CNT_W-1:0]   r_bad_cnt, w_bad_cnt_nxt;

    logic               r_dout_valid, w_dout_valid;
    logic               r_dout_sop, w_dout_sop;
    logic               r_dout_eop, w_dout_eop;
    logic [15:0]        r_dout, w_dout;
    logic               r_chk_valid, w_chk_valid;
    logic               r_chk_ok, w_chk_ok;
    logic               r_chk_err_crc, w_chk_err_crc;
    logic               r_chk_err_frame, w_chk_err_frame;

    logic               w_good_inc, w_bad_inc;
    logic [15:0]        w_crc_upd, w_crc_start;

    assign w_crc_upd   = crc_g(r_crc ^ i_din);
    assign w_crc_start = crc_g(INIT ^ i_din);

    always_comb begin
        w_state_nxt     = r_state;
        w_crc_nxt       = r_crc;
        w_hold_nxt      = r_hold;
        w_hold_sop_nxt  = r_hold_sop;
        w_dout_valid    = 1'b0;
        w_dout_sop      = 1'b0;
        w_dout_eop      = 1'b0;
        w_dout          = 16'h0000;
        w_chk_valid     = 1'b0;
        w_chk_ok        = 1'b0;
        w_chk_err_crc   = 1'b0;
        w_chk_err_frame = 1'b0;
        w_good_inc      = 1'b0;
        w_bad_inc       = 1'b0;

        if (i_din_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (i_din_sop && i_din_eop) begin
                        w_chk_valid     = 1'b1;
                        w_chk_err_frame = 1'b1;
                        w_bad_inc       = 1'b1;
                    end else if (i_din_sop) begin
                        w_crc_nxt      = w_crc_start;
                        w_hold_nxt     = i_din;
                        w_hold_sop_nxt = 1'b1;
                        w_state_nxt    = S_BODY;
                    end
                end
                S_BODY: begin
                    // Any accepted word in BODY releases the held payload word.
                    w_dout_valid = 1'b1;
                    w_dout       = r_hold;
                    w_dout_sop   = r_hold_sop;
                    if (i_din_sop) begin
                        w_dout_eop      = 1'b1;
                        w_chk_valid     = 1'b1;
                        w_chk_err_frame = 1'b1;
                        w_bad_inc       = 1'b1;
                        if (i_din_eop) begin
                            w_crc_nxt      = INIT;
                            w_hold_sop_nxt = 1'b0;
                            w_state_nxt    = S_IDLE;
                        end else begin
                            w_crc_nxt      = w_crc_start;
                            w_hold_nxt     = i_din;
                            w_hold_sop_nxt = 1'b1;
                        end
                    end else if (i_din_eop) begin
                        w_dout_eop  = 1'b1;
                        w_chk_valid = 1'b1;
                        if (w_crc_upd == 16'h0000) begin
                            w_chk_ok   = 1'b1;
                            w_good_inc = 1'b1;
                        end else begin
                            w_chk_err_crc = 1'b1;
                            w_bad_inc     = 1'b1;
                        end
                        w_crc_nxt      = INIT;
                        w_hold_sop_nxt = 1'b0;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_hold_nxt     = i_din;
                        w_hold_sop_nxt = 1'b0;
                        w_crc_nxt      = w_crc_upd;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        w_good_cnt_nxt = r_good_cnt;
        if (w_good_inc && (r_good_cnt != {CNT_W{1'b1}})) begin
            w_good_cnt_nxt = r_good_cnt + CNT_W'(1);
        end
        w_bad_cnt_nxt = r_bad_cnt;
        if (w_bad_inc && (r_bad_cnt != {CNT_W{1'b1}})) begin
            w_bad_cnt_nxt = r_bad_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_crc           <= INIT;
            r_hold          <= 16'h0000;
            r_hold_sop      <= 1'b0;
            r_good_cnt      <= '0;
            r_bad_cnt       <= '0;
            r_dout_valid    <= 1'b0;
            r_dout_sop      <= 1'b0;
            r_dout_eop      <= 1'b0;
            r_dout          <= 16'h0000;
            r_chk_valid     <= 1'b0;
            r_chk_ok        <= 1'b0;
            r_chk_err_crc   <= 1'b0;
            r_chk_err_frame <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_crc           <= w_crc_nxt;
            r_hold          <= w_hold_nxt;
            r_hold_sop      <= w_hold_sop_nxt;
            r_good_cnt      <= w_good_cnt_nxt;
            r_bad_cnt       <= w_bad_cnt_nxt;
            r_dout_valid    <= w_dout_valid;
            r_dout_sop      <= w_dout_sop;
            r_dout_eop      <= w_dout_eop;
            r_dout          <= w_dout;
            r_chk_valid     <= w_chk_valid;
            r_chk_ok        <= w_chk_ok;
            r_chk_err_crc   <= w_chk_err_crc;
            r_chk_err_frame <= w_chk_err_frame;
        end
    end

    assign o_dout_valid    = r_dout_valid;
    assign o_dout_sop      = r_dout_sop;
    assign o_dout_eop      = r_dout_eop;
    assign o_dout          = r_dout;
    assign o_chk_valid     = r_chk_valid;
    assign o_chk_ok        = r_chk_ok;
    assign o_chk_err_crc   = r_chk_err_crc;
    assign o_chk_err_frame = r_chk_err_frame;
    assign o_good_cnt      = r_good_cnt;
    assign o_bad_cnt       = r_bad_cnt;

endmodule

`default_nettype wire

// File: tb/tb_crc16_checker.sv
// ============================================================================
// tb_crc16_checker
// Directed self-checking bench for crc16_checker (default and CNT_W=2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_crc16_checker;

    logic        clk;
    logic        rst_n;
    logic        din_valid;
    logic        din_sop;
    logic        din_eop;
    logic [15:0] din;

    logic        dout_valid, dout_sop, dout_eop;
    logic [15:0] dout;
    logic        chk_valid, chk_ok, chk_err_crc, chk_err_frame;
    logic [15:0] good_cnt, bad_cnt;

    logic        s_dout_valid, s_dout_sop, s_dout_eop;
    logic [15:0] s_dout;
    logic        s_chk_valid, s_chk_ok, s_chk_err_crc, s_chk_err_frame;
    logic [1:0]  s_good_cnt, s_bad_cnt;

    int n_tests;
    int n_fail;

    crc16_checker dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_din_valid     (din_valid),
        .i_din_sop       (din_sop),
        .i_din_eop       (din_eop),
        .i_din           (din),
        .o_dout_valid    (dout_valid),
        .o_dout_sop      (dout_sop),
        .o_dout_eop      (dout_eop),
        .o_dout          (dout),
        .o_chk_valid     (chk_valid),
        .o_chk_ok        (chk_ok),
        .o_chk_err_crc   (chk_err_crc),
        .o_chk_err_frame (chk_err_frame),
        .o_good_cnt      (good_cnt),
        .o_bad_cnt       (bad_cnt)
    );

    crc16_checker #(.CNT_W(2)) dut_sat (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_din_valid     (din_valid),
        .i_din_sop       (din_sop),
        .i_din_eop       (din_eop),
        .i_din           (din),
        .o_dout_valid    (s_dout_valid),
        .o_dout_sop      (s_dout_sop),
        .o_dout_eop      (s_dout_eop),
        .o_dout          (s_dout),
        .o_chk_valid     (s_chk_valid),
        .o_chk_ok        (s_chk_ok),
        .o_chk_err_crc   (s_chk_err_crc),
        .o_chk_err_frame (s_chk_err_frame),
        .o_good_cnt      (s_good_cnt),
        .o_bad_cnt       (s_bad_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of input, then check the registered response.
    // exp_d = {valid, sop, eop, data}; exp_c = {chk_valid, ok, err_crc, err_frame}.
    task automatic step(input string tag, input logic v, input logic s, input logic e,
                        input logic [15:0] d, input logic [18:0] exp_d, input logic [3:0] exp_c);
        din_valid = v;
        din_sop   = s;
        din_eop   = e;
        din       = d;
        @(posedge clk);
        #1;
        check({tag, ".dout"}, {13'd0, dout_valid, dout_sop, dout_eop, dout}, {13'd0, exp_d});
        check({tag, ".chk"}, {28'd0, chk_valid, chk_ok, chk_err_crc, chk_err_frame}, {28'd0, exp_c});
        din_valid = 1'b0;
        din_sop   = 1'b0;
        din_eop   = 1'b0;
        din       = 16'h0000;
    endtask

    task automatic check_cnt(input string tag, input logic [15:0] eg, input logic [15:0] eb);
        check({tag, ".good"}, {16'd0, good_cnt}, {16'd0, eg});
        check({tag, ".bad"}, {16'd0, bad_cnt}, {16'd0, eb});
    endtask

    localparam logic [18:0] NO_D = 19'h0;
    localparam logic [3:0]  NO_C = 4'h0;
    localparam logic [3:0]  C_OK = 4'b1100;
    localparam logic [3:0]  C_EC = 4'b1010;
    localparam logic [3:0]  C_EF = 4'b1001;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        din_valid = 1'b0;
        din_sop   = 1'b0;
        din_eop   = 1'b0;
        din       = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst.dout", {13'd0, dout_valid, dout_sop, dout_eop, dout}, 32'd0);
        check("rst.chk", {28'd0, chk_valid, chk_ok, chk_err_crc, chk_err_frame}, 32'd0);
        check_cnt("rst", 16'd0, 16'd0);
        rst_n = 1'b1;

        // Single payload word 0000 with CRC 1D0F.
        step("f1.w0", 1, 1, 0, 16'h0000, NO_D, NO_C);
        step("f1.crc", 1, 0, 1, 16'h1D0F, {3'b111, 16'h0000}, C_OK);
        check_cnt("f1", 16'd1, 16'd0);
        step("f1.after", 0, 0, 0, 16'h0000, NO_D, NO_C);

        // Gaps inside a frame.
        step("f2.w0", 1, 1, 0, 16'hFFFF, NO_D, NO_C);
        step("f2.gap0", 0, 0, 0, 16'h0000, NO_D, NO_C);
        step("f2.gap1", 0, 0, 0, 16'h0000, NO_D, NO_C);
        step("f2.crc", 1, 0, 1, 16'h0000, {3'b111, 16'hFFFF}, C_OK);
        check_cnt("f2", 16'd2, 16'd0);

        // Corrupted CRC word.
        step("f3.w0", 1, 1, 0, 16'h0000, NO_D, NO_C);
        step("f3.crc", 1, 0, 1, 16'h1D0E, {3'b111, 16'h0000}, C_EC);
        check_cnt("f3", 16'd2, 16'd1);

        // Runt then orphan.
        step("runt", 1, 1, 1, 16'h1234, NO_D, C_EF);
        step("orphan", 1, 0, 0, 16'h5555, NO_D, NO_C);
        step("orphan.after", 0, 0, 0, 16'h0000, NO_D, NO_C);
        check_cnt("runt", 16'd2, 16'd2);

        // Abort: A,B then new frame {FFFF, 0000}.
        step("ab.a", 1, 1, 0, 16'h1111, NO_D, NO_C);
        step("ab.b", 1, 0, 0, 16'h2222, {3'b110, 16'h1111}, NO_C);
        step("ab.c", 1, 1, 0, 16'hFFFF, {3'b101, 16'h2222}, C_EF);
        check_cnt("ab.mid", 16'd2, 16'd3);
        step("ab.crc", 1, 0, 1, 16'h0000, {3'b111, 16'hFFFF}, C_OK);
        check_cnt("ab", 16'd3, 16'd3);
        check("sat.good3", {30'd0, s_good_cnt}, 32'd3);
        check("sat.bad3", {30'd0, s_bad_cnt}, 32'd3);

        // Abort by a sop&eop word: no second verdict, back to IDLE.
        step("ae.a", 1, 1, 0, 16'h1111, NO_D, NO_C);
        step("ae.runt", 1, 1, 1, 16'h9999, {3'b111, 16'h1111}, C_EF);
        step("ae.after", 0, 0, 0, 16'h0000, NO_D, NO_C);
        step("ae.orphan", 1, 0, 1, 16'h0000, NO_D, NO_C);
        check_cnt("ae", 16'd3, 16'd4);

        // Five more good frames: wide counter reaches 8, 2-bit one holds at 3.
        for (int i = 0; i < 5; i++) begin
            step("sat.w0", 1, 1, 0, 16'h0000, NO_D, NO_C);
            step("sat.crc", 1, 0, 1, 16'h1D0F, {3'b111, 16'h0000}, C_OK);
        end
        check_cnt("sat", 16'd8, 16'd4);
        check("sat.good", {30'd0, s_good_cnt}, 32'd3);
        check("sat.bad", {30'd0, s_bad_cnt}, 32'd3);

        // Reset in the middle of a frame.
        step("mr.w0", 1, 1, 0, 16'h0000, NO_D, NO_C);
        step("mr.w1", 1, 0, 0, 16'h1234, {3'b110, 16'h0000}, NO_C);
        rst_n = 1'b0;
        step("mr.rst", 1, 0, 1, 16'h0000, NO_D, NO_C);
        check_cnt("mr.rst", 16'd0, 16'd0);
        check("mr.sat", {28'd0, s_good_cnt, s_bad_cnt}, 32'd0);
        rst_n = 1'b1;
        step("mr.idle", 0, 0, 0, 16'h0000, NO_D, NO_C);
        step("mr.f.w0", 1, 1, 0, 16'h0000, NO_D, NO_C);
        step("mr.f.crc", 1, 0, 1, 16'h1D0F, {3'b111, 16'h0000}, C_OK);
        check_cnt("mr.f", 16'd1, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/crc16_checker.md
Name: crc16_checker

Overview:
- Receive-side counterpart of the team's 16-bit parallel CRC16 generator.
- Accepts framed 16-bit words whose last word (marked by eop) is the CRC of the preceding payload words.
- Verifies the CRC by residue check and strips the CRC word from the stream.
- Emits the payload with re-aligned sop/eop, a per-frame verdict pulse, and saturating good/bad frame counters. Sits between the link receiver and the payload consumer; no backpressure.

Parameters:
- INIT, 16'hFFFF, CRC register value loaded at each frame start.
- CNT_W, 16, width of the good/bad frame counters.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous, active-low reset.
- i_din_valid  in  1  input word valid.
- i_din_sop  in  1  first word of frame; qualified by i_din_valid.
- i_din_eop  in  1  last word of frame, which is the CRC word; qualified by i_din_valid.
- i_din  in  16  input word.
- o_dout_valid  out  1  stripped payload word valid.
- o_dout_sop  out  1  first payload word.
- o_dout_eop  out  1  last payload word, or terminating word of an aborted frame.
- o_dout  out  16  payload word.
- o_chk_valid  out  1  one-cycle verdict strobe.
- o_chk_ok  out  1  CRC matched; valid with o_chk_valid.
- o_chk_err_crc  out  1  residue nonzero; valid with o_chk_valid.
- o_chk_err_frame  out  1  runt or aborted frame; valid with o_chk_valid.
- o_good_cnt  out  CNT_W  frames passed, saturating.
- o_bad_cnt  out  CNT_W  frames failed, saturating.

Behaviour:
- CRC update: crc_next = G(crc ^ d). G(v) applies 16 iterations of v = {v[14:0],1'b0} ^ (v[15] ? 16'h1021 : 16'h0).
  - This is the x^16+x^12+x^5+1 polynomial, MSB-first, no reflection, no final XOR.
  - Implemented as a single-cycle XOR matrix.
- Every word of a frame, including the CRC word, passes through G. A frame passes iff the register after the CRC word is 16'h0000.
- Reset: state IDLE, crc=INIT, hold register cleared. All outputs 0, including counters.
- All outputs are registered. Every output strobe is a single cycle and is low otherwise.
- Two-state FSM: IDLE and BODY. One-word hold register (hold_data, hold_sop) delays the payload so the CRC word can be dropped.
- Cycles with i_din_valid=0: no state change. Gaps are allowed anywhere in a frame.
- IDLE, valid & ~sop: orphan word, dropped. No output, no verdict, no count.
- IDLE, valid & sop & ~eop:
  - crc = G(INIT ^ d); hold = d; hold_sop = 1; next state BODY.
- IDLE, valid & sop & eop: runt frame.
  - Next cycle: o_chk_valid=1, o_chk_err_frame=1, o_chk_ok=0, o_chk_err_crc=0.
  - o_bad_cnt increments. No payload output. Stays in IDLE.
- BODY, valid & ~sop & ~eop:
  - Next cycle: o_dout_valid=1, o_dout=hold, o_dout_sop=hold_sop, o_dout_eop=0.
  - Then hold = d; hold_sop = 0; crc = G(crc ^ d).
- BODY, valid & ~sop & eop:
  - Next cycle: o_dout_valid=1, o_dout=hold, o_dout_sop=hold_sop, o_dout_eop=1, o_chk_valid=1.
  - Verdict: o_chk_ok=1 if G(crc ^ d)==0; otherwise o_chk_err_crc=1.
  - Matching counter increments. The CRC word is never output. Next state IDLE; crc=INIT.
- BODY, valid & sop (abort):
  - Next cycle: held word is output with o_dout_eop=1, together with o_chk_valid=1 and o_chk_err_frame=1. o_bad_cnt increments.
  - If ~eop: the new word starts a frame exactly as in IDLE, and the state stays BODY.
  - If eop: the new word is discarded, no second verdict is given, and the state goes to IDLE.
- Latency: payload word k appears one cycle after word k+1 is accepted. The verdict appears one cycle after the eop word.
- Counters saturate at all-ones and never wrap. At most one counter increments per cycle.
- Reset asserted mid-frame: the frame is discarded silently, with no verdict and no output on the following cycle.

Test Plan:
- Frame {16'h0000, 16'h1D0F}: one payload word 0000 with o_dout_sop=o_dout_eop=1; o_chk_ok=1; good_cnt=1.
- Frame {16'hFFFF, 16'h0000} with two idle cycles between the words: payload FFFF output; o_chk_ok=1; verdict exactly one cycle after the eop word.
- Frame {16'h0000, 16'h1D0E}: payload 0000 still output; o_chk_err_crc=1; bad_cnt=1; good_cnt unchanged.
- Runt (sop&eop, 16'h1234), then an orphan word 16'h5555 in IDLE: one err_frame verdict; no o_dout_valid; bad_cnt=1; the orphan has no effect.
- Words A, B accepted, then sop on C followed by {C, crc}:
  - A is output with sop.
  - B is output with eop, together with err_frame.
  - The new frame is verified independently and passes.
- CNT_W=2: five good frames leave good_cnt=3. Reset mid-frame leaves all outputs 0, and a following {0000, 1D0F} frame passes.
